alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter LAT, default 1, meaning: ALU evaluation cycles (1..15) that operands are held stable before result capture.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Req0Valid/Req1Valid  input  1  requester N presents an operation.
REQ-005 Req0SrcA/Req1SrcA, Req0SrcB/Req1SrcB  input  32  operands of requester N.
REQ-006 Req0Ctrl/Req1Ctrl  input  3  ALU op code of requester N (000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT).
REQ-007 Req0Ready/Req1Ready  output  1  arbiter accepts requester N this cycle.
REQ-008 Rsp0Valid/Rsp1Valid  output  1  response for requester N is on RspResult/RspZero/RspErr.
REQ-009 Rsp0Ready/Rsp1Ready  input  1  requester N consumes the response.
REQ-010 RspResult  output  32; RspZero  output  1; RspErr  output  1  shared response bus.
REQ-011 SrcA, SrcB  output  32; ALUControl  output  3  drive the shared ALU.
REQ-012 ALUResult  input  32; Zero  input  1  ALU outputs (combinational).

Function
REQ-013 FSM states IDLE, EXEC, RESP; exactly one operation in flight.
REQ-014 IDLE: ReqNReady=1 only for granted requester N; other Ready=0; no Ready outside IDLE.
REQ-015 Grant: single valid requester wins; both valid -> per arbitration policy (REQ-027/028).
REQ-016 Accept (ReqNValid & ReqNReady): register SrcA, SrcB, Ctrl, owner id; load cycle counter with LAT-1; -> EXEC.
REQ-017 SrcA/SrcB/ALUControl driven only from operand registers; stable throughout EXEC and held outside it.
REQ-018 EXEC: counter decrements each cycle; at counter==0 capture ALUResult->RspResult, Zero->RspZero; -> RESP; EXEC lasts exactly LAT cycles.
REQ-019 Invalid Ctrl (011, 111): accepted; in EXEC, ALU output ignored; RspResult=0, RspZero=1, RspErr=1.
REQ-020 Valid Ctrl: RspErr=0.
REQ-021 RESP: RspNValid=1 for owner only; RspResult/RspZero/RspErr stable until handshake.
REQ-022 RESP with owner RspNReady=1 -> IDLE next cycle; Rsp valid drops; arbitration pointer updated to owner.
REQ-023 Back-to-back: minimum issue interval LAT+2 cycles per operation; no acceptance in the RESP handshake cycle.
REQ-024 Requester may drop ReqNValid before acceptance without side effect; arbiter never reads operands except on accept.
REQ-025 RspNReady of non-owner ignored.

Reset
REQ-026 rst_n low (any cycle, incl. EXEC/RESP): state=IDLE, ReqNReady per IDLE grant with no valid -> 0, RspNValid=0, RspResult=0, RspZero=1, RspErr=0, operand regs=0, ALUControl=000, counter=0, pointer=1; in-flight operation discarded, no response issued.

Configuration
REQ-027 ALU_ARB_RR_EN defined: round-robin; both valid -> grant requester not equal to pointer (after reset Req0 first).
REQ-028 ALU_ARB_RR_EN undefined: fixed priority, Req0 always wins contention; pointer unused; all other behaviour identical.

Verification
REQ-029 Req0 ADD 5+7, LAT=1, Rsp0Ready=1 -> Req0Ready cycle 0, Rsp0Valid cycle 2, RspResult=12, RspZero=0, RspErr=0.
REQ-030 Req1 SUB 9-9, Rsp1Ready held 0 for 3 cycles -> Rsp1Valid held, RspResult=0, RspZero=1 stable, no new accept.
REQ-031 Both valid continuously, ops AND/OR, RR_EN defined -> grants alternate 0,1,0,1; undefined -> only Req0 granted.
REQ-032 Req0 Ctrl=111, SrcA=3, SrcB=4 -> RspResult=0, RspZero=1, RspErr=1.
REQ-033 LAT=4, MUL 0x10000*0x10 -> SrcA/SrcB stable 4 EXEC cycles, RspResult=0x00100000 at cycle 5.
REQ-034 rst_n pulsed low during EXEC -> no RspValid afterwards, outputs at reset values, next request served normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Purpose : arbitrates two requesters onto one shared combinational ALU; one operation in flight.
// Latency : accept -> LAT EXEC cycles -> response valid on the following cycle.
// Backpressure: response held stable until owner RspNReady; no new accept until the RESP handshake completes.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ReqN{Valid,SrcA,SrcB,Ctrl}      request from requester N (N = 0,1)
//   ReqNReady                       requester N accepted this cycle
//   RspNValid / RspNReady           response handshake for requester N
//   RspResult, RspZero, RspErr      shared response bus
//   SrcA, SrcB, ALUControl          drive the shared ALU (from operand registers only)
//   ALUResult, Zero                 shared ALU outputs
// Config macro: ALU_ARB_RR_EN  (defined: round-robin on contention; undefined: Req0 fixed priority)

module alu_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req0Valid,
    input  logic        Req1Valid,
    input  logic [31:0] Req0SrcA,
    input  logic [31:0] Req1SrcA,
    input  logic [31:0] Req0SrcB,
    input  logic [31:0] Req1SrcB,
    input  logic [2:0]  Req0Ctrl,
    input  logic [2:0]  Req1Ctrl,
    output logic        Req0Ready,
    output logic        Req1Ready,
    output logic        Rsp0Valid,
    output logic        Rsp1Valid,
    input  logic        Rsp0Ready,
    input  logic        Rsp1Ready,
    output logic [31:0] RspResult,
    output logic        RspZero,
    output logic        RspErr,
    output logic [31:0] SrcA,
    output logic [31:0] SrcB,
    output logic [2:0]  ALUControl,
    input  logic [31:0] ALUResult,
    input  logic        Zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t      state;
    logic        owner;
    logic [3:0]  cnt;
    logic [31:0] src_a_q;
    logic [31:0] src_b_q;
    logic [2:0]  ctrl_q;
    logic        prio0;
    logic        grant0;
    logic        grant1;
    logic        ctrl_ok;
    logic        owner_rdy;

`ifdef ALU_ARB_RR_EN
    // ptr holds the last served requester; contention goes to the other one.
    logic ptr;
    assign prio0 = ptr;
`else
    assign prio0 = 1'b1;
`endif

    assign grant0 = Req0Valid & (~Req1Valid | prio0);
    assign grant1 = Req1Valid & (~Req0Valid | ~prio0);

    assign Req0Ready = (state == IDLE) & grant0;
    assign Req1Ready = (state == IDLE) & grant1;

    assign SrcA       = src_a_q;
    assign SrcB       = src_b_q;
    assign ALUControl = ctrl_q;

    // 011 and 111 are not ALU operations; they are still accepted but answered with an error.
    assign ctrl_ok   = (ctrl_q != 3'b011) && (ctrl_q != 3'b111);
    assign owner_rdy = owner ? Rsp1Ready : Rsp0Ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            cnt       <= 4'd0;
            src_a_q   <= 32'd0;
            src_b_q   <= 32'd0;
            ctrl_q    <= 3'b000;
            Rsp0Valid <= 1'b0;
            Rsp1Valid <= 1'b0;
            RspResult <= 32'd0;
            RspZero   <= 1'b1;
            RspErr    <= 1'b0;
`ifdef ALU_ARB_RR_EN
            ptr       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Req0Ready || Req1Ready) begin
                        src_a_q <= Req1Ready ? Req1SrcA : Req0SrcA;
                        src_b_q <= Req1Ready ? Req1SrcB : Req0SrcB;
                        ctrl_q  <= Req1Ready ? Req1Ctrl : Req0Ctrl;
                        owner   <= Req1Ready;
                        cnt     <= CNT_INIT;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        if (ctrl_ok) begin
                            RspResult <= ALUResult;
                            RspZero   <= Zero;
                            RspErr    <= 1'b0;
                        end else begin
                            RspResult <= 32'd0;
                            RspZero   <= 1'b1;
                            RspErr    <= 1'b1;
                        end
                        Rsp0Valid <= ~owner;
                        Rsp1Valid <= owner;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (owner_rdy) begin
                        Rsp0Valid <= 1'b0;
                        Rsp1Valid <= 1'b0;
                        state     <= IDLE;
`ifdef ALU_ARB_RR_EN
                        ptr       <= owner;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : randomized scoreboard bench for alu_arbiter against a behavioural model.
// Latency : expects response valid LAT+1 cycles after the accept cycle.
// Backpressure: random Rsp ready on both requesters; random request drop before accept; reset injected in EXEC.

module tb_alu_arbiter;

    localparam int LAT    = 3;
    localparam int NCYC   = 4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Req0Valid, Req1Valid;
    logic [31:0] Req0SrcA, Req1SrcA, Req0SrcB, Req1SrcB;
    logic [2:0]  Req0Ctrl, Req1Ctrl;
    logic        Req0Ready, Req1Ready;
    logic        Rsp0Valid, Rsp1Valid;
    logic        Rsp0Ready, Rsp1Ready;
    logic [31:0] RspResult;
    logic        RspZero, RspErr;
    logic [31:0] SrcA, SrcB;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero;

    always #5 clk = ~clk;

    alu_arbiter #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
        .Req0SrcA(Req0SrcA), .Req1SrcA(Req1SrcA),
        .Req0SrcB(Req0SrcB), .Req1SrcB(Req1SrcB),
        .Req0Ctrl(Req0Ctrl), .Req1Ctrl(Req1Ctrl),
        .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
        .Rsp0Valid(Rsp0Valid), .Rsp1Valid(Rsp1Valid),
        .Rsp0Ready(Rsp0Ready), .Rsp1Ready(Rsp1Ready),
        .RspResult(RspResult), .RspZero(RspZero), .RspErr(RspErr),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .ALUResult(ALUResult), .Zero(Zero)
    );

    // Shared ALU environment: garbage on unsupported codes so the arbiter must ignore it.
    always_comb begin
        ALUResult = 32'hDEAD_BEEF;
        Zero      = 1'b0;
        case (ALUControl)
            3'b000: ALUResult = SrcA & SrcB;
            3'b001: ALUResult = SrcA | SrcB;
            3'b010: ALUResult = SrcA + SrcB;
            3'b100: ALUResult = SrcA - SrcB;
            3'b101: ALUResult = SrcA * SrcB;
            3'b110: ALUResult = {31'd0, $signed(SrcA) < $signed(SrcB)};
            default: ALUResult = 32'hDEAD_BEEF;
        endcase
        if (ALUControl != 3'b011 && ALUControl != 3'b111)
            Zero = (ALUResult == 32'd0);
    end

    typedef struct {
        logic        owner;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic ptr    = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Reference model: response computed from the operation rules with plain arithmetic.
    function automatic exp_t model(input logic owner, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] ctrl, input int acc);
        exp_t e;
        longint unsigned prod;
        e.owner = owner; e.a = a; e.b = b; e.ctrl = ctrl; e.acc = acc;
        e.err = 1'b0;
        prod = longint'(a) * longint'(b);
        case (ctrl)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: e.res = 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            3'd4: e.res = 32'((longint'(a) + 64'h1_0000_0000 - longint'(b)) % 64'h1_0000_0000);
            3'd5: e.res = prod[31:0];
            3'd6: e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: begin e.res = 32'd0; e.err = 1'b1; end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic new_op(output logic [31:0] a, output logic [31:0] b, output logic [2:0] c);
        c = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
            1: begin a = $urandom; b = a; end
            2: begin a = 32'h0001_0000; b = 32'h10; end
            default: begin a = $urandom; b = $urandom; end
        endcase
    endtask

    // Monitor: pops and compares the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        logic ev;
        #1;
        if (!rst_n) begin
            q.delete();
            ptr = 1'b1;
            check("rst_rsp0_valid", Rsp0Valid, 0);
            check("rst_rsp1_valid", Rsp1Valid, 0);
            check("rst_result", RspResult, 0);
            check("rst_zero", RspZero, 1);
            check("rst_err", RspErr, 0);
            check("rst_srca", SrcA, 0);
            check("rst_srcb", SrcB, 0);
            check("rst_aluctrl", ALUControl, 0);
            check("rst_req0_ready", Req0Ready, 0);
            check("rst_req1_ready", Req1Ready, 0);
        end else if (q.size() != 0) begin
            e = q[0];
            if (cyc > e.acc) begin
                check("srca_hold", SrcA, e.a);
                check("srcb_hold", SrcB, e.b);
                check("aluctrl_hold", ALUControl, e.ctrl);
            end
            ev = (cyc >= e.acc + LAT + 1);
            check("rsp0_valid", Rsp0Valid, ev && !e.owner);
            check("rsp1_valid", Rsp1Valid, ev && e.owner);
            if (ev) begin
                check("rsp_result", RspResult, e.res);
                check("rsp_zero", RspZero, e.zero);
                check("rsp_err", RspErr, e.err);
                if (e.owner ? Rsp1Ready : Rsp0Ready) begin
                    void'(q.pop_front());
                    ptr = e.owner;
                end
            end
        end else begin
            check("idle_rsp0_valid", Rsp0Valid, 0);
            check("idle_rsp1_valid", Rsp1Valid, 0);
        end
    end

    // Driver: issues random requests, checks grants, pushes expected responses on accept.
    initial begin
        logic prio0, eg0, eg1, busy;
        int   rst_hold = 0;
        int   resets_left = 4;
        rst_n = 1'b0;
        Req0Valid = 0; Req1Valid = 0;
        Req0SrcA = 0; Req0SrcB = 0; Req0Ctrl = 0;
        Req1SrcA = 0; Req1SrcB = 0; Req1Ctrl = 0;
        Rsp0Ready = 0; Rsp1Ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            eg0 = 1'b0; eg1 = 1'b0;
            if (rst_n) begin
                busy = (q.size() != 0);
`ifdef ALU_ARB_RR_EN
                prio0 = ptr;
`else
                prio0 = 1'b1;
`endif
                eg0 = !busy && Req0Valid && (!Req1Valid || prio0);
                eg1 = !busy && Req1Valid && (!Req0Valid || !prio0);
                check("req0_ready", Req0Ready, eg0);
                check("req1_ready", Req1Ready, eg1);
                if (eg0) q.push_back(model(1'b0, Req0SrcA, Req0SrcB, Req0Ctrl, cyc));
                if (eg1) q.push_back(model(1'b1, Req1SrcA, Req1SrcB, Req1Ctrl, cyc));
            end

            @(posedge clk);
            #1;
            Rsp0Ready = ($urandom_range(0, 2) != 0);
            Rsp1Ready = ($urandom_range(0, 2) != 0);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if (resets_left > 0 && q.size() != 0 && cyc > q[0].acc &&
                         cyc <= q[0].acc + LAT && $urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                Req0Valid = 0; Req1Valid = 0;
                rst_hold = 2;
                resets_left--;
            end else begin
                if (eg0) Req0Valid = 0;
                if (eg1) Req1Valid = 0;
                if (!Req0Valid) begin
                    if ($urandom_range(0, 1) == 0) begin
                        new_op(Req0SrcA, Req0SrcB, Req0Ctrl);
                        Req0Valid = 1;
                    end
                end else if ($urandom_range(0, 7) == 0) Req0Valid = 0;
                if (!Req1Valid) begin
                    if ($urandom_range(0, 1) == 0) begin
                        new_op(Req1SrcA, Req1SrcB, Req1Ctrl);
                        Req1Valid = 1;
                    end
                end else if ($urandom_range(0, 7) == 0) Req1Valid = 0;
            end
        end

        // Drain: stop requesting, accept every response, bounded wait.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        Req0Valid = 0; Req1Valid = 0;
        Rsp0Ready = 1; Rsp1Ready = 1;
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        #2;
        check("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
